// File: rtl/store_buffer.sv
// Posted-write FIFO between the execute/memory stage and DataMemory: drains one store per
// free memory cycle and stalls loads whose word range overlaps any buffered store.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             ld_valid,
  input  logic [2:0]       ld_op,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             drain_req,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       MemRead,
  output logic [1:0]       MemWrite,
  output logic [31:0]      Address,
  output logic [31:0]      dataToMem
);

  localparam int PTR_W = CNT_W - 1;

  localparam logic [1:0] MEMWRITE_SB = 2'b01;
  localparam logic [1:0] MEMWRITE_SH = 2'b10;
  localparam logic [2:0] MEMREAD_LB  = 3'b001;
  localparam logic [2:0] MEMREAD_LH  = 3'b010;
  localparam logic [2:0] MEMREAD_LBU = 3'b100;
  localparam logic [2:0] MEMREAD_LHU = 3'b101;

  logic [1:0]       op_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       ldSize;
  logic [31:0]      ldEnd;
  logic [31:0]      stEnd  [DEPTH];
  logic [PTR_W-1:0] offset [DEPTH];
  logic             overlapHit;
  logic             loadIssue;
  logic             drain;
  logic             enq;

  always_comb begin
    ldSize = 3'd4;
    case (ld_op)
      MEMREAD_LB, MEMREAD_LBU: ldSize = 3'd1;
      MEMREAD_LH, MEMREAD_LHU: ldSize = 3'd2;
      default:                 ldSize = 3'd4;
    endcase
    ldEnd = ld_addr + {29'b0, ldSize} - 32'd1;
  end

  // An entry is live when its distance from the head is below the count; live entries
  // are compared on both words so misaligned accesses spanning a boundary are caught.
  always_comb begin
    overlapHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offset[i] = PTR_W'(i) - rdPtr_q;
      case (op_q[i])
        MEMWRITE_SB: stEnd[i] = addr_q[i];
        MEMWRITE_SH: stEnd[i] = addr_q[i] + 32'd1;
        default:     stEnd[i] = addr_q[i] + 32'd3;
      endcase
      if (({1'b0, offset[i]} < count_q) &&
          (addr_q[i][31:2] <= ldEnd[31:2]) &&
          (ld_addr[31:2] <= stEnd[i][31:2]))
        overlapHit = 1'b1;
    end
  end

  always_comb begin
    st_ready  = (count_q < CNT_W'(DEPTH)) && !drain_req;
    enq       = st_valid && st_ready && (st_op != 2'b00);
    ld_stall  = ld_valid && overlapHit;
    loadIssue = ld_valid && !ld_stall;
    drain     = (count_q != '0) && !loadIssue;
    empty     = (count_q == '0);
    count     = count_q;
    MemRead   = ld_op;
    MemWrite  = drain ? op_q[rdPtr_q] : 2'b00;
    Address   = loadIssue ? ld_addr : addr_q[rdPtr_q];
    dataToMem = data_q[rdPtr_q];

    wrPtr_d = enq   ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = drain ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= 2'b00;
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (enq) begin
        op_q[wrPtr_q]   <= st_op;
        addr_q[wrPtr_q] <= st_addr;
        data_q[wrPtr_q] <= st_data;
      end
    end
  end

endmodule
